// File: rtl/serdes_lb_pkg.sv
// Shared definitions for the CC_SERDES loopback pattern: FSM states, K28.5 marker and the
// default transmitted frame, which the TX pattern side reuses.
package serdes_lb_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lb_state_t;

  localparam logic [7:0]  K28_5        = 8'hBC;
  localparam logic [63:0] EXP_DATA_DEF = 64'h0000_0000_00CA_FEBC;
  localparam logic [7:0]  EXP_K_DEF    = 8'h01;

endpackage

// File: rtl/serdes_rx_lane_align.sv
// Two-stage RX pipeline: stage 1 holds the current and previous words, stage 2 holds the
// frame realigned to the selected marker lane. Everything stalls while valid is low.
module serdes_rx_lane_align
  import serdes_lb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        lane,
  input  logic [63:0] data,
  input  logic [7:0]  k,
  input  logic [7:0]  err,
  output logic [63:0] s1_data,
  output logic [7:0]  s1_k,
  output logic        s1_valid,
  output logic [63:0] frame_data,
  output logic [7:0]  frame_k,
  output logic [7:0]  frame_err,
  output logic        frame_valid
);

  logic [63:0] prev_data;
  logic [7:0]  prev_k;
  logic [7:0]  s1_err;
  logic [7:0]  prev_err;

  // Lane 1 takes the upper half of the older word as the low half of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data     <= '0;
      s1_k        <= '0;
      s1_err      <= '0;
      s1_valid    <= 1'b0;
      prev_data   <= '0;
      prev_k      <= '0;
      prev_err    <= '0;
      frame_data  <= '0;
      frame_k     <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
    end else if (valid) begin
      s1_data     <= data;
      s1_k        <= k;
      s1_err      <= err;
      s1_valid    <= 1'b1;
      prev_data   <= s1_data;
      prev_k      <= s1_k;
      prev_err    <= s1_err;
      frame_valid <= s1_valid;
      if (lane) begin
        frame_data <= {s1_data[31:0], prev_data[63:32]};
        frame_k    <= {s1_k[3:0], prev_k[7:4]};
        frame_err  <= {s1_err[3:0], prev_err[7:4]};
      end else begin
        frame_data <= s1_data;
        frame_k    <= s1_k;
        frame_err  <= s1_err;
      end
    end
  end

endmodule

// File: rtl/serdes_rx_checker.sv
// Loopback RX checker: K28.5 lane hunt, frame compare, lock FSM and saturating counters.
// Define SERDES_RX_CHECK_DISPERR_EN to make code/disparity errors force a frame mismatch.
module serdes_rx_checker
  import serdes_lb_pkg::*;
#(
  parameter logic [63:0] EXP_DATA   = EXP_DATA_DEF,
  parameter logic [7:0]  EXP_K      = EXP_K_DEF,
  parameter int          LOCK_CNT   = 8,
  parameter int          UNLOCK_CNT = 4,
  parameter int          ERR_W      = 16
)(
  input  logic             rx_clk_i,
  input  logic             rx_rst_i,
  input  logic             rx_valid_i,
  input  logic [63:0]      rx_data_i,
  input  logic [7:0]       rx_char_is_k_i,
  input  logic [7:0]       rx_not_in_table_i,
  input  logic [7:0]       rx_disp_err_i,
  input  logic             clear_i,
  output logic             lock_o,
  output logic             lane_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [31:0]      word_cnt_o
);

  logic [7:0]  flag_in;
  logic [63:0] s1_data;
  logic [7:0]  s1_k;
  logic        s1_valid;
  logic [63:0] frame_data;
  logic [7:0]  frame_k;
  logic [7:0]  frame_err;
  logic        frame_valid;

`ifdef SERDES_RX_CHECK_DISPERR_EN
  assign flag_in = rx_not_in_table_i | rx_disp_err_i;
`else
  logic unused_flags;
  assign flag_in      = 8'h00;
  assign unused_flags = ^{rx_not_in_table_i, rx_disp_err_i};
`endif

  serdes_rx_lane_align u_align (
    .clk         (rx_clk_i),
    .rst         (rx_rst_i),
    .valid       (rx_valid_i),
    .lane        (lane_o),
    .data        (rx_data_i),
    .k           (rx_char_is_k_i),
    .err         (flag_in),
    .s1_data     (s1_data),
    .s1_k        (s1_k),
    .s1_valid    (s1_valid),
    .frame_data  (frame_data),
    .frame_k     (frame_k),
    .frame_err   (frame_err),
    .frame_valid (frame_valid)
  );

  lb_state_t  state;
  logic [7:0] good_run;
  logic [7:0] bad_run;
  logic       skip;
  logic       marker0;
  logic       marker4;
  logic       match;
  logic       compare;

  assign marker0 = s1_k[0] && (s1_data[7:0] == K28_5);
  assign marker4 = s1_k[4] && (s1_data[39:32] == K28_5);
  assign match   = (frame_data == EXP_DATA) && (frame_k == EXP_K) && (frame_err == 8'h00);
  // The frame sitting in stage 2 at the lane decision was built with the old lane, so skip it.
  assign compare = rx_valid_i && frame_valid && (state != HUNT) && !skip;
  assign lock_o  = (state == LOCKED);

  always_ff @(posedge rx_clk_i or posedge rx_rst_i) begin
    if (rx_rst_i) begin
      state    <= HUNT;
      lane_o   <= 1'b0;
      err_o    <= 1'b0;
      good_run <= '0;
      bad_run  <= '0;
      skip     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (rx_valid_i) begin
        skip <= 1'b0;
        case (state)
          HUNT: begin
            if (s1_valid && marker0) begin
              lane_o   <= 1'b0;
              state    <= VERIFY;
              skip     <= 1'b1;
              good_run <= '0;
            end else if (s1_valid && marker4) begin
              lane_o   <= 1'b1;
              state    <= VERIFY;
              skip     <= 1'b1;
              good_run <= '0;
            end
          end
          VERIFY: begin
            if (compare) begin
              if (!match) begin
                state    <= HUNT;
                good_run <= '0;
              end else if (good_run == 8'(LOCK_CNT - 1)) begin
                state    <= LOCKED;
                good_run <= '0;
                bad_run  <= '0;
              end else begin
                good_run <= good_run + 8'd1;
              end
            end
          end
          LOCKED: begin
            if (compare) begin
              if (match) begin
                bad_run <= '0;
              end else begin
                err_o <= 1'b1;
                if (bad_run == 8'(UNLOCK_CNT - 1)) begin
                  state   <= HUNT;
                  bad_run <= '0;
                end else begin
                  bad_run <= bad_run + 8'd1;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Clear takes priority over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge rx_clk_i or posedge rx_rst_i) begin
    if (rx_rst_i) begin
      err_cnt_o  <= '0;
      word_cnt_o <= '0;
    end else if (clear_i) begin
      err_cnt_o  <= '0;
      word_cnt_o <= '0;
    end else if (compare && (state == LOCKED)) begin
      if (word_cnt_o != 32'hFFFF_FFFF)
        word_cnt_o <= word_cnt_o + 32'd1;
      if (!match && (err_cnt_o != {ERR_W{1'b1}}))
        err_cnt_o <= err_cnt_o + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_serdes_rx_checker.sv
// Directed bench for serdes_rx_checker (ERR_W = 4): lane 0/1 lock, errors, unlock,
// saturation, clear, valid gaps, async reset and the SERDES_RX_CHECK_DISPERR_EN option.
module tb_serdes_rx_checker;

  localparam logic [63:0] W0 = 64'h0000_0000_00CA_FEBC;
  localparam logic [63:0] W1 = 64'h00CA_FEBC_0000_0000;
`ifdef SERDES_RX_CHECK_DISPERR_EN
  localparam logic DISP_ON = 1'b1;
`else
  localparam logic DISP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [63:0] data = '0;
  logic [7:0]  k = '0;
  logic [7:0]  nit = '0;
  logic [7:0]  disp = '0;
  logic        clr = 1'b0;
  logic        lock;
  logic        lane;
  logic        err;
  logic [3:0]  err_cnt;
  logic [31:0] word_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        valid;
    logic [63:0] data;
    logic [7:0]  k;
    logic        lock;
    logic        err;
    logic [3:0]  ec;
    logic [31:0] wc;
  } vec_t;

  vec_t vecs[19];

  serdes_rx_checker #(.ERR_W(4)) dut (
    .rx_clk_i          (clk),
    .rx_rst_i          (rst),
    .rx_valid_i        (valid),
    .rx_data_i         (data),
    .rx_char_is_k_i    (k),
    .rx_not_in_table_i (nit),
    .rx_disp_err_i     (disp),
    .clear_i           (clr),
    .lock_o            (lock),
    .lane_o            (lane),
    .err_o             (err),
    .err_cnt_o         (err_cnt),
    .word_cnt_o        (word_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic bad, logic lk, logic e, logic [3:0] ec, logic [31:0] wc);
    vec_t v;
    v.valid = 1'b1;
    v.data  = bad ? 64'h0 : W0;
    v.k     = bad ? 8'h00 : 8'h01;
    v.lock  = lk;
    v.err   = e;
    v.ec    = ec;
    v.wc    = wc;
    return v;
  endfunction

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] kk,
                               input logic [7:0] de, input logic c);
    valid = v;
    data  = d;
    k     = kk;
    disp  = de;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_lock, input logic e_lane,
                             input logic e_err, input logic [3:0] e_ec, input logic [31:0] e_wc);
    tests++;
    if (lock !== e_lock || lane !== e_lane || err !== e_err || err_cnt !== e_ec || word_cnt !== e_wc) begin
      fails++;
      $display("[TB] FAIL %s: got lock=%0b lane=%0b err=%0b err_cnt=%0d word_cnt=%0d, expected lock=%0b lane=%0b err=%0b err_cnt=%0d word_cnt=%0d",
               name, lock, lane, err, err_cnt, word_cnt, e_lock, e_lane, e_err, e_ec, e_wc);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Marker seen one edge after the first word, one skipped frame, then 8 matches.
    for (int i = 0; i < 10; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 4'd0, 32'd1);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 4'd0, 32'd2);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 4'd0, 32'd3);
    vecs[14] = mk(1'b1, 1'b1, 1'b1, 4'd1, 32'd4);
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 4'd2, 32'd5);
    vecs[16] = mk(1'b0, 1'b1, 1'b1, 4'd3, 32'd6);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 4'd4, 32'd7);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 4'd4, 32'd7);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].k, 8'h00, 1'b0);
      checkOutput($sformatf("lane0 row %0d", i + 1), vecs[i].lock, 1'b0, vecs[i].err,
                  vecs[i].ec, vecs[i].wc);
    end

    repeat (8) applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    checkOutput("relock pending", 1'b0, 1'b0, 1'b0, 4'd4, 32'd7);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    checkOutput("relock", 1'b1, 1'b0, 1'b0, 4'd4, 32'd7);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 64'h0, 8'h00, 8'h00, 1'b0);
      applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    end
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    checkOutput("err_cnt saturation", 1'b1, 1'b0, 1'b0, 4'd15, 32'd49);

    applyStimulus(1'b1, 64'h0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b1);
    checkOutput("clear beats error", 1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    checkOutput("after clear", 1'b1, 1'b0, 1'b0, 4'd0, 32'd1);

    // A bad word entering stage 1 must ride through valid gaps before it is compared.
    applyStimulus(1'b1, 64'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("gap step 1", 1'b1, 1'b0, 1'b0, 4'd0, 32'd2);
    applyStimulus(1'b0, 64'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("gap step 2", 1'b1, 1'b0, 1'b0, 4'd0, 32'd2);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    checkOutput("gap step 3", 1'b1, 1'b0, 1'b0, 4'd0, 32'd3);
    applyStimulus(1'b0, 64'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("gap step 4", 1'b1, 1'b0, 1'b0, 4'd0, 32'd3);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    checkOutput("gap step 5", 1'b1, 1'b0, 1'b1, 4'd1, 32'd4);
    applyStimulus(1'b0, 64'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("gap step 6", 1'b1, 1'b0, 1'b0, 4'd1, 32'd4);
    applyStimulus(1'b1, W0, 8'h01, 8'h00, 1'b0);
    checkOutput("gap step 7", 1'b1, 1'b0, 1'b0, 4'd1, 32'd5);

    #3;
    rst = 1'b1;
    #1;
    checkOutput("async reset mid-lock", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 1; i <= 14; i++) begin
      applyStimulus(1'b1, W1, 8'h10, 8'h00, 1'b0);
      if (i == 1)
        checkOutput("lane1 first word", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      else if (i == 2)
        checkOutput("lane1 marker", 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
      else if (i == 10)
        checkOutput("lane1 pre-lock", 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
      else if (i >= 11)
        checkOutput($sformatf("lane1 locked %0d", i), 1'b1, 1'b1, 1'b0, 4'd0, 32'(i - 11));
    end

    applyStimulus(1'b1, W1, 8'h10, 8'h02, 1'b0);
    applyStimulus(1'b1, W1, 8'h10, 8'h00, 1'b0);
    checkOutput("disp err pending", 1'b1, 1'b1, 1'b0, 4'd0, 32'd5);
    applyStimulus(1'b1, W1, 8'h10, 8'h00, 1'b0);
    checkOutput("disp err frame", 1'b1, 1'b1, DISP_ON, {3'b000, DISP_ON}, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serdes_rx_checker.md
# serdes_rx_checker

Receive-side link checker that sits directly downstream of the CC_SERDES RX PCS in the loopback test designs. It consumes the 64-bit decoded RX data and per-byte K flags on the CDR clock, finds the K28.5 marker in byte lane 0 or 4, and realigns the stream to a fixed 64-bit frame. It compares each frame against the fixed transmitted pattern and runs a hunt/verify/locked state machine. It reports lock, error pulses and saturating error and word counters for LEDs and debug.

## Interface
Parameters:
- EXP_DATA, 64'h0000_0000_00CA_FEBC, expected realigned frame (K28.5 in byte 0)
- EXP_K, 8'h01, expected per-byte K flags of the realigned frame
- LOCK_CNT, 8, consecutive matching frames in VERIFY needed to enter LOCKED (1..255)
- UNLOCK_CNT, 4, consecutive mismatching frames in LOCKED needed to drop to HUNT (1..255)
- ERR_W, 16, width of the error counter

Ports:
- rx_clk_i  in  1  CDR recovered clock; the only clock
- rx_rst_i  in  1  asynchronous, active-high reset
- rx_valid_i  in  1  input word valid; tied to RX reset-done
- rx_data_i  in  64  decoded RX data
- rx_char_is_k_i  in  8  per-byte K flag
- rx_not_in_table_i  in  8  per-byte code violation
- rx_disp_err_i  in  8  per-byte disparity error
- clear_i  in  1  synchronous counter clear
- lock_o  out  1  high in LOCKED
- lane_o  out  1  selected marker lane: 0 = byte 0, 1 = byte 4
- err_o  out  1  one-cycle pulse per mismatching frame in LOCKED
- err_cnt_o  out  ERR_W  saturating mismatch count
- word_cnt_o  out  32  saturating count of frames compared in LOCKED

## Operation
- Stage 1 registers the input word and flags when rx_valid_i = 1. It keeps the previous word for realignment.
- Stage 2 forms the frame:
  - lane 0: the current word.
  - lane 1: bytes 4..7 of the previous word as frame bytes 0..3, and bytes 0..3 of the current word as frame bytes 4..7. K and error flags are rotated the same way.
- A frame matches when data == EXP_DATA and K == EXP_K. Without the macro, error flags are ignored.
- HUNT:
  - The raw stage-1 word is scanned for byte 8'hBC with its K flag set.
  - Found in lane 0: lane_o <= 0, go to VERIFY. Found in lane 4: lane_o <= 1, go to VERIFY.
  - Found in both lanes: lane 0 wins.
- VERIFY:
  - On a match, good_run increments. When good_run reaches LOCK_CNT, go to LOCKED.
  - Any mismatch clears good_run and returns to HUNT.
- LOCKED:
  - Each compared frame increments word_cnt_o.
  - A mismatch pulses err_o, increments err_cnt_o and increments bad_run. A match clears bad_run.
  - When bad_run reaches UNLOCK_CNT, go to HUNT. That last mismatch is still counted.
- lane_o changes only when leaving HUNT.
- Both counters saturate at all-ones and do not wrap.
- clear_i zeroes both counters. If clear_i and an error arrive in the same cycle, clear wins and the counter reads 0. The state machine is unaffected by clear_i.
- rx_valid_i = 0 freezes the pipeline, FSM and counters. No compare happens and err_o = 0.
- Reset values: lock_o = 0, lane_o = 0, err_o = 0, err_cnt_o = 0, word_cnt_o = 0. State = HUNT, all run counters 0, pipeline registers 0.

## Timing
- Latency from the rx_clk_i edge that samples a valid word to the registered compare result is 2 clocks. err_o, err_cnt_o and word_cnt_o update at that edge.
- lock_o rises on the same edge as the compare result of the LOCK_CNT-th matching frame. It falls on the same edge as the compare result of the UNLOCK_CNT-th bad frame.
- In lane-1 mode, the first frame after a lane decision is built from a previous word already held in stage 1, so no extra bubble is added.
- Reset asserted mid-operation clears everything asynchronously. After release, hunting restarts on the next valid word.

## Configuration
- SERDES_RX_CHECK_DISPERR_EN
  - Defined: any set bit in the rotated rx_not_in_table_i or rx_disp_err_i of a frame forces a mismatch, even if data and K match.
  - Undefined: those inputs are unused and only data/K are compared.

## Structure
- Shared package serdes_lb_pkg holds:
  - the state enum {HUNT, VERIFY, LOCKED}
  - K28_5 = 8'hBC
  - the default EXP_DATA/EXP_K constants, reused by the TX pattern side
- One natural sub-module, serdes_rx_lane_align. It holds the stage-1/stage-2 registers and lane rotation, and outputs the frame, K flags and error flags with a valid.

## Test plan
- Lane 0 lock: after reset, drive EXP_DATA with K = 8'h01 every cycle → lock_o rises on the edge 2 + 8 cycles after the first valid word (marker found, then 8 matches), lane_o = 0, err_cnt_o = 0.
- Lane 1 lock: drive the stream byte-rotated by 4 (words 64'h00CA_FEBC_0000_0000, K = 8'h10) → lane_o = 1, lock after 8 matching frames, word_cnt_o increments once per cycle while locked.
- Error and unlock: while locked, inject 3 bad frames (data 64'h0) → 3 err_o pulses, err_cnt_o = 3, lock held. A 4th consecutive bad frame → err_cnt_o = 4, lock_o = 0, state HUNT.
- Saturation and clear: set ERR_W = 4 and inject 20 isolated errors → err_cnt_o stops at 15. clear_i in the same cycle as an error → err_cnt_o = 0.
- Valid gaps and reset: toggle rx_valid_i 1/0 while locked → counters advance only on valid words. Assert rx_rst_i mid-lock → all outputs 0 immediately.
- With SERDES_RX_CHECK_DISPERR_EN defined: a matching frame with rx_disp_err_i = 8'h02 → err_o pulses. With the macro undefined, the same frame → no error.
